// File: rtl/audio_scheduler_pkg.sv
// audio_pkg: shared constants, state encoding and chord-root helper for the audio scheduler
package audio_pkg;
  localparam logic [4:0] SILENT_ID = 5'd31;
  localparam int MAX_ID = 23;
  localparam logic [4:0] PROG_OFFSET [0:3] = '{5'd0, 5'd5, 5'd7, 5'd0};
  typedef enum logic [2:0] {IDLE, TONE, TONE_GAP, CHORD, CHORD_GAP} state_t;
  // Root of the chord at a progression step, folded down an octave when it leaves the legal id range.
  function automatic logic [4:0] chord_root(input logic [4:0] key, input logic [1:0] step);
    logic [5:0] sum;
    sum = {1'b0, key} + {1'b0, PROG_OFFSET[step]};
    chord_root = (key > 5'(MAX_ID)) ? SILENT_ID : (sum > 6'(MAX_ID)) ? 5'(sum - 6'd12) : sum[4:0];
  endfunction
endpackage

// File: rtl/audio_scheduler_if.sv
// audio_scheduler_if: tone request, progression control and audio-side outputs of the scheduler
interface audio_scheduler_if;
  logic       tone_valid;
  logic       tone_ready;
  logic [4:0] tone_id1;
  logic [4:0] tone_id2;
  logic [1:0] tone_dur;
  logic       music_en;
  logic [4:0] key;
  logic [4:0] freq_id1;
  logic [4:0] freq_id2;
  logic       new_f;
  logic       music;
  logic [1:0] step;
  logic       busy;
  modport master (
    output tone_valid, tone_id1, tone_id2, tone_dur, music_en, key,
    input  tone_ready, freq_id1, freq_id2, new_f, music, step, busy
  );
  modport slave (
    input  tone_valid, tone_id1, tone_id2, tone_dur, music_en, key,
    output tone_ready, freq_id1, freq_id2, new_f, music, step, busy
  );
endinterface

// File: rtl/audio_scheduler_tone_fifo.sv
// tone_fifo: small synchronous FIFO buffering game tone requests
module tone_fifo #(
  parameter int W   = 12,
  parameter int LOG = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int DEPTH = 1 << LOG;
  logic [W-1:0]   mem_q [DEPTH];
  logic [LOG-1:0] wp_q, rp_q;
  logic [LOG:0]   cnt_q;
  logic           push_ok, pop_ok;
  assign full_o  = cnt_q == (LOG+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rp_q];
  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wp_q <= wp_q + 1'b1;
      if (pop_ok) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (LOG+1)'(push_ok) - (LOG+1)'(pop_ok);
    end
  end
  // Storage needs no reset; only slots behind the write pointer are ever read.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wp_q] <= data_i;
  end
endmodule

// File: rtl/audio_scheduler.sv
// audio_scheduler: shares the audio datapath between queued game tones and a I-IV-V-I chord loop
module audio_scheduler
  import audio_pkg::*;
#(
  parameter int NOTE_LENGTH = 20,
  parameter int SIL_LENGTH  = 17,
  parameter int FIFO_LOG    = 2
) (
  input logic               clock,
  input logic               reset,
  audio_scheduler_if.slave  bus
);
  localparam int CW = ((NOTE_LENGTH + 3) > (SIL_LENGTH + 1)) ? (NOTE_LENGTH + 3) : (SIL_LENGTH + 1);
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    f1_q, f1_d, f2_q, f2_d;
  logic          newf_q, newf_d, music_q, music_d;
  logic [1:0]    step_q, step_d;
  logic [11:0]   head;
  logic          full, empty, push, pop, abort;
  assign bus.tone_ready = reset && !full;
  assign push           = bus.tone_valid && bus.tone_ready;
  assign abort          = !bus.music_en && (state_q == CHORD || state_q == CHORD_GAP);
  assign bus.freq_id1   = f1_q;
  assign bus.freq_id2   = f2_q;
  assign bus.new_f      = newf_q;
  assign bus.music      = music_q;
  assign bus.step       = step_q;
  assign bus.busy       = state_q != IDLE;
  tone_fifo #(.W(12), .LOG(FIFO_LOG)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({bus.tone_id1, bus.tone_id2, bus.tone_dur}),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  // Next state: tones beat chords in IDLE; a disabled progression aborts a chord even at gap expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f1_d    = f1_q;
    f2_d    = f2_q;
    newf_d  = 1'b0;
    music_d = music_q;
    step_d  = step_q;
    pop     = 1'b0;
    if (abort) begin
      f1_d    = SILENT_ID;
      f2_d    = SILENT_ID;
      music_d = 1'b0;
      newf_d  = 1'b1;
      step_d  = 2'd0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            pop          = 1'b1;
            {f1_d, f2_d} = head[11:2];
            music_d      = 1'b0;
            newf_d       = 1'b1;
            cnt_d        = CW'(head[1:0] + 3'd1) << NOTE_LENGTH;
            state_d      = TONE;
          end else if (bus.music_en) begin
            f1_d    = chord_root(bus.key, step_q);
            f2_d    = SILENT_ID;
            music_d = 1'b1;
            newf_d  = 1'b1;
            cnt_d   = CW'(1) << NOTE_LENGTH;
            state_d = CHORD;
          end
        end
        TONE, CHORD: begin
          if (cnt_q == CW'(1)) begin
            f1_d    = SILENT_ID;
            f2_d    = SILENT_ID;
            newf_d  = 1'b1;
            cnt_d   = CW'(1) << SIL_LENGTH;
            state_d = (state_q == TONE) ? TONE_GAP : CHORD_GAP;
          end else cnt_d = cnt_q - 1'b1;
        end
        default: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            step_d  = (state_q == CHORD_GAP) ? step_q + 2'd1 : step_q;
            music_d = (state_q == CHORD_GAP) ? 1'b0 : music_q;
          end else cnt_d = cnt_q - 1'b1;
        end
      endcase
    end
  end
  // State and registered audio-side outputs; reset silences everything without a pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f1_q    <= SILENT_ID;
      f2_q    <= SILENT_ID;
      newf_q  <= 1'b0;
      music_q <= 1'b0;
      step_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      newf_q  <= newf_d;
      music_q <= music_d;
      step_q  <= step_d;
    end
  end
endmodule
